// File: rtl/subckt_bist_pkg.sv
// Shared definitions for the subcircuit BIST controller.
// Contents: sequencer state encoding, signature width, and the
//           feedback polynomial taps shared by the generator and the MISR.
package subckt_bist_pkg;

  localparam int SIG_W = 16;

  // x^16 + x^14 + x^13 + x^11 + 1, expressed as the register bits XORed
  // into the feedback: 15, 13, 12 and 10.
  localparam logic [SIG_W-1:0] POLY_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_APPLY   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } bist_state_t;

  // One feedback bit: parity of the tapped register bits.
  function automatic logic poly_feedback(input logic [SIG_W-1:0] v);
    return ^(v & POLY_TAPS);
  endfunction

endpackage

// File: rtl/subckt_bist_ctrl_shift16.sv
// 16-bit left-shifting feedback register used as pattern generator or MISR.
// Ports: clk; load/load_val (synchronous load, has priority); en (step);
//        in_bit (XORed into bit 0 on each step); q (register contents).
module bist_shift16
  import subckt_bist_pkg::*;
(
  input  logic             clk,
  input  logic             load,
  input  logic [SIG_W-1:0] load_val,
  input  logic             en,
  input  logic             in_bit,
  output logic [SIG_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= {q[SIG_W-2:0], poly_feedback(q)} ^ {{(SIG_W-1){1'b0}}, in_bit};
    end
  end

endmodule

// File: rtl/subckt_bist_ctrl.sv
// BIST sequencer for one clocked subcircuit: resets it, drives LFSR patterns,
// compacts its output into a MISR (latency-aligned), and checks the signature.
// Ports: I1470_clk/I1477_rst (sync active-high); start/abort control;
//        dut_out observed; dut_in/dut_rst_n drive the subcircuit;
//        busy/done/pass/signature/pat_cnt report status.
module subckt_bist_ctrl
  import subckt_bist_pkg::*;
#(
  parameter int               N_IN       = 5,
  parameter int               N_PATTERNS = 64,
  parameter int               LAT        = 2,
  parameter logic [SIG_W-1:0] LFSR_SEED  = 16'hACE1,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic                                I1470_clk,
  input  logic                                I1477_rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                dut_out,
  output logic [N_IN-1:0]                     dut_in,
  output logic                                dut_rst_n,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic [SIG_W-1:0]                    signature,
  output logic [$clog2(N_PATTERNS+1)-1:0]     pat_cnt
);

  localparam int PCW = $clog2(N_PATTERNS + 1);

  // Reject parameter sets the schedule cannot honour.
  if (N_PATTERNS <= LAT) begin : g_bad_npat
    $error("subckt_bist_ctrl: N_PATTERNS must exceed LAT");
  end
  if (LAT < 1 || LAT > 8) begin : g_bad_lat
    $error("subckt_bist_ctrl: LAT must be 1..8");
  end
  if (N_IN < 1 || N_IN > 16) begin : g_bad_nin
    $error("subckt_bist_ctrl: N_IN must be 1..16");
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("subckt_bist_ctrl: LFSR_SEED must be nonzero");
  end

  bist_state_t      state, state_nxt;
  logic [SIG_W-1:0] lfsr;
  logic [SIG_W-1:0] misr;
  logic [3:0]       drain_cnt;
  logic             last_pat;
  logic             last_drain;
  logic             cap_en;
  logic             launch;
  logic             unused_lfsr;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort beats start in IDLE, so a simultaneous pair never launches.
  assign launch     = start && !abort;
  assign last_pat   = (pat_cnt == PCW'(N_PATTERNS - 1));
  assign last_drain = (drain_cnt == 4'(LAT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (launch) state_nxt = ST_FLUSH;
      ST_FLUSH:   state_nxt = abort ? ST_IDLE : ST_APPLY;
      ST_APPLY: begin
        if (abort)         state_nxt = ST_IDLE;
        else if (last_pat) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort)           state_nxt = ST_IDLE;
        else if (last_drain) state_nxt = ST_COMPARE;
      end
      ST_COMPARE: state_nxt = abort ? ST_IDLE : ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Status outputs decoded from state
  // ---------------------------------------------------------------------
  assign busy      = (state == ST_FLUSH) || (state == ST_APPLY) ||
                     (state == ST_DRAIN) || (state == ST_COMPARE);
  assign done      = (state == ST_DONE);
  // Subcircuit leaves reset on the very cycle pattern 0 is presented.
  assign dut_rst_n = (state == ST_APPLY) || (state == ST_DRAIN) ||
                     (state == ST_COMPARE);
  assign dut_in    = (state == ST_APPLY) ? lfsr[N_IN-1:0] : '0;

  // pat_cnt is the index of the pattern on dut_in during APPLY; the first
  // LAT responses are still in the subcircuit pipeline, so capture starts
  // at index LAT and DRAIN collects the last LAT responses.
  assign cap_en = ((state == ST_APPLY) && (pat_cnt >= PCW'(LAT))) ||
                  (state == ST_DRAIN);

  // ---------------------------------------------------------------------
  // Counters and result registers
  // ---------------------------------------------------------------------
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      pat_cnt   <= '0;
      drain_cnt <= '0;
      pass      <= 1'b0;
      signature <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            pass      <= 1'b0;
            signature <= '0;
          end
        end
        ST_FLUSH: begin
          pat_cnt   <= '0;
          drain_cnt <= '0;
        end
        ST_APPLY:   pat_cnt   <= pat_cnt + 1'b1;
        ST_DRAIN:   drain_cnt <= drain_cnt + 1'b1;
        ST_COMPARE: begin
          signature <= misr;
          pass      <= (misr == GOLDEN_SIG);
        end
        default: ;
      endcase
      // A cancelled run leaves no result behind, including from COMPARE.
      if (abort && busy) begin
        pass      <= 1'b0;
        signature <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pattern generator and signature compactor
  // ---------------------------------------------------------------------
  bist_shift16 u_gen (
    .clk      (I1470_clk),
    .load     (I1477_rst || (state == ST_FLUSH)),
    .load_val (LFSR_SEED),
    .en       (state == ST_APPLY),
    .in_bit   (1'b0),
    .q        (lfsr)
  );

  bist_shift16 u_misr (
    .clk      (I1470_clk),
    .load     (I1477_rst || (state == ST_FLUSH)),
    .load_val ({SIG_W{1'b0}}),
    .en       (cap_en),
    .in_bit   (dut_out),
    .q        (misr)
  );

  // Generator bits above N_IN only matter to the shifter's own feedback.
  assign unused_lfsr = ^lfsr;

endmodule

// File: tb/tb_subckt_bist_ctrl.sv
// Self-checking bench for subckt_bist_ctrl with default parameters.
// Ports: drives clock/reset/start/abort and a modelled subcircuit output;
//        observes every controller output.
module tb_subckt_bist_ctrl;

  localparam int          N_IN   = 5;
  localparam int          N_PAT  = 64;
  localparam int          LAT    = 2;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam logic [15:0] GOLD   = 16'h0000;
  localparam int          DONE_T = N_PAT + LAT + 3;   // 69

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            dut_out;
  logic [N_IN-1:0] dut_in;
  logic            dut_rst_n;
  logic            busy;
  logic            done;
  logic            pass;
  logic [15:0]     signature;
  logic [6:0]      pat_cnt;

  // 0: output tied 0, 1: tied 1, 2: parity of inputs through a LAT-deep pipe
  logic [1:0]      mode = 2'd0;
  logic [1:0]      pipe;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  subckt_bist_ctrl #(
    .N_IN(N_IN), .N_PATTERNS(N_PAT), .LAT(LAT),
    .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD)
  ) dut (
    .I1470_clk (clk),
    .I1477_rst (rst),
    .start     (start),
    .abort     (abort),
    .dut_out   (dut_out),
    .dut_in    (dut_in),
    .dut_rst_n (dut_rst_n),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature),
    .pat_cnt   (pat_cnt)
  );

  // Behavioural subcircuit with two cycles of latency.
  always_ff @(posedge clk) begin
    if (!dut_rst_n) pipe <= '0;
    else            pipe <= {pipe[0], ^dut_in};
  end
  assign dut_out = (mode == 2'd2) ? pipe[1] : mode[0];

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] sig;
    logic        pass;
  } vec_t;
  vec_t vecs[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] step16(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference signature: response to pattern k is compacted as step k.
  function automatic logic [15:0] model_sig(input logic [1:0] m);
    logic [15:0]      g;
    logic [15:0]      s;
    logic [N_PAT-1:0] par;
    g = SEED;
    s = '0;
    for (int k = 0; k < N_PAT; k++) begin
      par[k] = ^g[N_IN-1:0];
      g = step16(g);
    end
    for (int k = 0; k < N_PAT; k++) begin
      s = step16(s) ^ {15'b0, (m == 2'd2) ? par[k] : m[0]};
    end
    return s;
  endfunction

  // One full run from IDLE; returns with the controller back in IDLE.
  task automatic run_one(input logic [1:0] m, input logic [15:0] esig,
                         input logic epass, input bit repulse);
    int t;
    int done_t;
    int ndone;
    int nbusy;
    mode   = m;
    t      = 0;
    done_t = -1;
    ndone  = 0;
    check("idle_busy", busy, 0);
    start = 1'b1;
    while (t < 200 && (done_t < 0 || t <= done_t)) begin
      tick();
      t++;
      start = repulse && (t == 5 || t == 40);
      if (t == 1) begin
        check("flush_busy", busy, 1);
        check("flush_rst_n", dut_rst_n, 0);
      end
      if (t == 2) check("apply_rst_n", dut_rst_n, 1);
      if (done) begin
        ndone++;
        if (done_t < 0) begin
          done_t = t;
          check("sig", signature, esig);
          check("pass", pass, epass);
          check("pat_cnt_end", pat_cnt, N_PAT);
        end
      end
    end
    start = 1'b0;
    check("done_cycle", done_t, DONE_T);
    check("done_count", ndone, 1);
    check("post_busy", busy, 0);
    if (repulse) begin
      nbusy = 0;
      repeat (4) begin
        tick();
        if (busy || done) nbusy++;
      end
      check("no_queued_run", nbusy, 0);
    end
  endtask

  initial begin
    int t;
    int nd;

    vecs[0].mode = 2'd0; vecs[0].sig = 16'h0000;     vecs[0].pass = 1'b1;
    vecs[1].mode = 2'd1; vecs[1].sig = model_sig(1); vecs[1].pass = 1'b0;
    vecs[2].mode = 2'd2; vecs[2].sig = model_sig(2); vecs[2].pass = (model_sig(2) == GOLD);

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_sig", signature, 0);
    check("rst_pat_cnt", pat_cnt, 0);
    check("rst_dut_rst_n", dut_rst_n, 0);
    check("rst_dut_in", dut_in, 0);
    rst = 1'b0;
    tick();

    // Generator sequence on dut_in
    mode  = 2'd0;
    start = 1'b1;
    t = 0;
    tick(); t++;
    start = 1'b0;
    tick(); t++;
    check("lfsr_pat0", dut_in, 5'b00001);
    tick(); t++;
    check("lfsr_pat1", dut_in, 5'b00011);
    while (t < 66) begin tick(); t++; end
    check("drain_busy", busy, 1);
    check("drain_dut_in", dut_in, 0);
    while (!done && t < 200) begin tick(); t++; end
    check("lfsr_run_done_t", t, DONE_T);
    tick();

    // Table-driven back-to-back runs
    for (int i = 0; i < 3; i++) begin
      run_one(vecs[i].mode, vecs[i].sig, vecs[i].pass, 1'b0);
    end

    // Abort at APPLY index 10
    mode  = 2'd2;
    start = 1'b1;
    t = 0;
    tick(); t++;
    start = 1'b0;
    while (t < 12) begin tick(); t++; end
    check("abort_at_idx", pat_cnt, 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rst_n", dut_rst_n, 0);
    check("abort_pass", pass, 0);
    check("abort_sig", signature, 0);
    check("abort_dut_in", dut_in, 0);
    nd = 0;
    repeat (80) begin
      tick();
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);

    // abort together with start in IDLE does not launch
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", busy, 0);
    check("abort_start_rst_n", dut_rst_n, 0);

    // Reset pulse during DRAIN, then a clean rerun
    mode  = 2'd2;
    start = 1'b1;
    t = 0;
    tick(); t++;
    start = 1'b0;
    while (t < 66) begin tick(); t++; end
    check("pre_rst_busy", busy, 1);
    check("pre_rst_pat_cnt", pat_cnt, N_PAT);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pass", pass, 0);
    check("midrst_sig", signature, 0);
    check("midrst_pat_cnt", pat_cnt, 0);
    check("midrst_rst_n", dut_rst_n, 0);
    check("midrst_dut_in", dut_in, 0);
    run_one(vecs[2].mode, vecs[2].sig, vecs[2].pass, 1'b0);

    // start re-pulsed while busy is ignored
    run_one(2'd0, 16'h0000, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
